// File: rtl/definitions_pkg.sv
// Shared definitions for the commit_monitor slice: monitor FSM states and the default tohost address.
package definitions_pkg;

    typedef enum logic [1:0] {
        MON_IDLE,
        MON_RUN,
        MON_DRAIN,
        MON_DONE
    } mon_state_e;

    localparam logic [63:0] TOHOST_ADDR_DEF = 64'h7F8;

endpackage

// File: rtl/commit_monitor_chk_delay_line.sv
// chk_delay_line: DEPTH-deep valid/payload shift register with a synchronous active-low clear.
module chk_delay_line #(
    parameter int unsigned DEPTH = 1,
    parameter int unsigned W     = 8
) (
    input  logic         clk_i,
    input  logic         clr_ni,
    input  logic         push_valid_i,
    input  logic [W-1:0] push_data_i,
    output logic         tail_valid_o,
    output logic [W-1:0] tail_data_o
);

    logic [DEPTH-1:0]        valid_q;
    logic [DEPTH-1:0][W-1:0] data_q;

    always_ff @(posedge clk_i) begin
        if (!clr_ni) begin
            valid_q <= '0;
            data_q  <= '0;
        end else begin
            valid_q[0] <= push_valid_i;
            data_q[0]  <= push_data_i;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                valid_q[i] <= valid_q[i-1];
                data_q[i]  <= data_q[i-1];
            end
        end
    end

    assign tail_valid_o = valid_q[DEPTH-1];
    assign tail_data_o  = data_q[DEPTH-1];

endmodule

// File: rtl/commit_monitor.sv
// commit_monitor: reads back every tapped RF/data-RAM write CHECK_LAT cycles later and reports the
// riscv-tests TOHOST verdict. Define COMMIT_MONITOR_MEM_CHECK_EN to build the data-RAM check channel.
module commit_monitor
    import definitions_pkg::*;
#(
    parameter int unsigned       XLEN         = 64,
    parameter int unsigned       ADDR_W       = 12,
    parameter int unsigned       CHECK_LAT    = 1,
    parameter int unsigned       DRAIN_CYCLES = 6,
    parameter logic [ADDR_W-1:0] TOHOST_ADDR  = ADDR_W'(TOHOST_ADDR_DEF),
    parameter int unsigned       CNT_W        = 32
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              en_i,
    input  logic              rf_we_i,
    input  logic [4:0]        rf_a_i,
    input  logic [XLEN-1:0]   rf_d_i,
    output logic [4:0]        rf_rb_a_o,
    input  logic [XLEN-1:0]   rf_rb_d_i,
    input  logic              mem_we_i,
    input  logic [ADDR_W-1:0] mem_a_i,
    input  logic [XLEN-1:0]   mem_wd_i,
    input  logic [XLEN/8-1:0] mem_be_i,
    output logic [ADDR_W-1:0] mem_rb_a_o,
    input  logic [XLEN-1:0]   mem_rb_d_i,
    output logic [CNT_W-1:0]  cycle_cnt_o,
    output logic [CNT_W-1:0]  reg_err_cnt_o,
    output logic [CNT_W-1:0]  mem_err_cnt_o,
    output logic [CNT_W-1:0]  chk_cnt_o,
    output logic [XLEN-1:0]   tohost_val_o,
    output logic              err_o,
    output logic              done_o,
    output logic              pass_o
);

    localparam int unsigned BE_W    = XLEN / 8;
    localparam int unsigned OFF_W   = $clog2(BE_W);
    localparam int unsigned DRAIN_W = $clog2(DRAIN_CYCLES + 2);
    localparam int unsigned RF_A_W  = 5;

    typedef struct packed {
        logic [RF_A_W-1:0] addr;
        logic [XLEN-1:0]   data;
    } reg_entry_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [XLEN-1:0]   data;
        logic [BE_W-1:0]   be;
    } mem_entry_t;

    mon_state_e        state_q;
    logic [DRAIN_W-1:0] drain_q;
    logic              run_c, tohost_hit_c, drain_end_c, done_nx_c, pass_nx_c;
    logic [ADDR_W-1:0] mem_word_a_c;
    logic [XLEN-1:0]   tohost_nx_c;
    logic              reg_tail_v, reg_mis_c, mem_tail_v, mem_mis_c;
    reg_entry_t        reg_push, reg_tail;
    logic [1:0]        chk_inc_c;
    logic [CNT_W-1:0]  reg_err_nx_c, mem_err_nx_c;

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a, input logic [1:0] inc);
        logic [CNT_W:0] sum;
        sum = {1'b0, a} + (CNT_W+1)'(inc);
        return sum[CNT_W] ? '1 : sum[CNT_W-1:0];
    endfunction

    assign run_c        = (state_q == MON_RUN) || (state_q == MON_DRAIN);
    assign mem_word_a_c = {mem_a_i[ADDR_W-1:OFF_W], OFF_W'(0)};
    assign tohost_hit_c = (state_q == MON_RUN) && mem_we_i && (mem_word_a_c == TOHOST_ADDR)
                          && mem_be_i[0] && mem_wd_i[0];
    assign drain_end_c  = (state_q == MON_DRAIN) && (drain_q == DRAIN_W'(DRAIN_CYCLES));

    // Register-file channel: x0 writes are never queued.
    assign reg_push = '{addr: rf_a_i, data: rf_d_i};

    chk_delay_line #(.DEPTH(CHECK_LAT), .W($bits(reg_entry_t))) u_reg_line (
        .clk_i        (clk_i),
        .clr_ni       (rst_ni),
        .push_valid_i (run_c && rf_we_i && (rf_a_i != RF_A_W'(0))),
        .push_data_i  (reg_push),
        .tail_valid_o (reg_tail_v),
        .tail_data_o  (reg_tail)
    );

    assign rf_rb_a_o = reg_tail.addr;
    assign reg_mis_c = reg_tail_v && (rf_rb_d_i != reg_tail.data);

`ifdef COMMIT_MONITOR_MEM_CHECK_EN
    mem_entry_t      mem_push, mem_tail;
    logic [XLEN-1:0] be_mask_c;
    logic            unused_c;

    assign mem_push = '{addr: mem_word_a_c, data: mem_wd_i, be: mem_be_i};

    chk_delay_line #(.DEPTH(CHECK_LAT), .W($bits(mem_entry_t))) u_mem_line (
        .clk_i        (clk_i),
        .clr_ni       (rst_ni),
        .push_valid_i (run_c && mem_we_i),
        .push_data_i  (mem_push),
        .tail_valid_o (mem_tail_v),
        .tail_data_o  (mem_tail)
    );

    // Only the byte lanes the store actually wrote take part in the compare.
    always_comb begin
        be_mask_c = '0;
        for (int unsigned b = 0; b < BE_W; b++) begin
            be_mask_c[8*b +: 8] = {8{mem_tail.be[b]}};
        end
    end

    assign mem_rb_a_o = mem_tail.addr;
    assign mem_mis_c  = mem_tail_v && (((mem_rb_d_i ^ mem_tail.data) & be_mask_c) != '0);
    assign unused_c   = ^mem_a_i[OFF_W-1:0];
`else
    logic unused_c;

    assign mem_tail_v = 1'b0;
    assign mem_mis_c  = 1'b0;
    assign mem_rb_a_o = '0;
    assign unused_c   = ^{mem_a_i[OFF_W-1:0], mem_rb_d_i, mem_be_i[BE_W-1:1]};
`endif

    assign chk_inc_c    = {1'b0, reg_tail_v} + {1'b0, mem_tail_v};
    assign reg_err_nx_c = sat_add(reg_err_cnt_o, {1'b0, reg_mis_c});
    assign mem_err_nx_c = sat_add(mem_err_cnt_o, {1'b0, mem_mis_c});
    assign tohost_nx_c  = tohost_hit_c ? mem_wd_i : tohost_val_o;
    assign done_nx_c    = done_o | drain_end_c;
    assign pass_nx_c    = done_nx_c && (tohost_nx_c == XLEN'(1))
                          && (reg_err_nx_c == '0) && (mem_err_nx_c == '0);

    // Control FSM plus registered counters; checks keep retiring after DONE.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q       <= MON_IDLE;
            drain_q       <= '0;
            cycle_cnt_o   <= '0;
            reg_err_cnt_o <= '0;
            mem_err_cnt_o <= '0;
            chk_cnt_o     <= '0;
            tohost_val_o  <= '0;
            err_o         <= 1'b0;
            done_o        <= 1'b0;
            pass_o        <= 1'b0;
        end else begin
            case (state_q)
                MON_IDLE: if (en_i) state_q <= MON_RUN;
                MON_RUN: begin
                    if (tohost_hit_c) begin
                        state_q <= MON_DRAIN;
                        drain_q <= '0;
                    end
                end
                MON_DRAIN: begin
                    if (drain_end_c) state_q <= MON_DONE;
                    else             drain_q <= drain_q + DRAIN_W'(1);
                end
                default: ;
            endcase
            if (run_c) cycle_cnt_o <= sat_add(cycle_cnt_o, 2'd1);
            chk_cnt_o     <= sat_add(chk_cnt_o, chk_inc_c);
            reg_err_cnt_o <= reg_err_nx_c;
            mem_err_cnt_o <= mem_err_nx_c;
            err_o         <= reg_mis_c | mem_mis_c;
            tohost_val_o  <= tohost_nx_c;
            done_o        <= done_nx_c;
            pass_o        <= pass_nx_c;
        end
    end

endmodule

// File: tb/tb_commit_monitor.sv
// Directed bench for commit_monitor: one CHECK_LAT=1 and one CHECK_LAT=3 instance share the taps
// and a behavioural RF/RAM model whose read-back path can be corrupted per location.
module tb_commit_monitor;

`ifdef COMMIT_MONITOR_MEM_CHECK_EN
    localparam int MEMC = 1;
`else
    localparam int MEMC = 0;
`endif

    logic        clk, rst_n, en;
    logic        rf_we, mem_we;
    logic [4:0]  rf_a;
    logic [63:0] rf_d, mem_wd;
    logic [11:0] mem_a;
    logic [7:0]  mem_be;

    logic [4:0]  rf_rb_a1, rf_rb_a3;
    logic [11:0] mem_rb_a1, mem_rb_a3;
    logic [63:0] rf_rb_d1, rf_rb_d3, mem_rb_d1, mem_rb_d3;
    logic [31:0] cyc1, rerr1, merr1, chk1, cyc3, rerr3, merr3, chk3;
    logic [63:0] toh1, toh3;
    logic        err1, done1, pass1, err3, done3, pass3;

    logic [63:0] rf_m  [32];
    logic [63:0] mem_m [512];
    logic [31:0] rf_corrupt;
    logic [8:0]  mcor_idx;
    logic [63:0] mcor_mask;

    int n_pass, n_fail, n_total;

    commit_monitor #(.CHECK_LAT(1)) u_dut (
        .clk_i(clk), .rst_ni(rst_n), .en_i(en),
        .rf_we_i(rf_we), .rf_a_i(rf_a), .rf_d_i(rf_d), .rf_rb_a_o(rf_rb_a1), .rf_rb_d_i(rf_rb_d1),
        .mem_we_i(mem_we), .mem_a_i(mem_a), .mem_wd_i(mem_wd), .mem_be_i(mem_be),
        .mem_rb_a_o(mem_rb_a1), .mem_rb_d_i(mem_rb_d1),
        .cycle_cnt_o(cyc1), .reg_err_cnt_o(rerr1), .mem_err_cnt_o(merr1), .chk_cnt_o(chk1),
        .tohost_val_o(toh1), .err_o(err1), .done_o(done1), .pass_o(pass1)
    );

    commit_monitor #(.CHECK_LAT(3)) u_dut3 (
        .clk_i(clk), .rst_ni(rst_n), .en_i(en),
        .rf_we_i(rf_we), .rf_a_i(rf_a), .rf_d_i(rf_d), .rf_rb_a_o(rf_rb_a3), .rf_rb_d_i(rf_rb_d3),
        .mem_we_i(mem_we), .mem_a_i(mem_a), .mem_wd_i(mem_wd), .mem_be_i(mem_be),
        .mem_rb_a_o(mem_rb_a3), .mem_rb_d_i(mem_rb_d3),
        .cycle_cnt_o(cyc3), .reg_err_cnt_o(rerr3), .mem_err_cnt_o(merr3), .chk_cnt_o(chk3),
        .tohost_val_o(toh3), .err_o(err3), .done_o(done3), .pass_o(pass3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural register file and byte-enabled data RAM behind the taps.
    always @(posedge clk) begin
        if (rf_we && rf_a != 5'd0) rf_m[rf_a] <= rf_d;
        if (mem_we) begin
            for (int b = 0; b < 8; b++) begin
                if (mem_be[b]) mem_m[mem_a[11:3]][8*b +: 8] <= mem_wd[8*b +: 8];
            end
        end
    end

    assign rf_rb_d1  = rf_corrupt[rf_rb_a1] ? 64'h0 : rf_m[rf_rb_a1];
    assign rf_rb_d3  = rf_corrupt[rf_rb_a3] ? 64'h0 : rf_m[rf_rb_a3];
    assign mem_rb_d1 = mem_m[mem_rb_a1[11:3]] ^ ((mem_rb_a1[11:3] == mcor_idx) ? mcor_mask : 64'h0);
    assign mem_rb_d3 = mem_m[mem_rb_a3[11:3]] ^ ((mem_rb_a3[11:3] == mcor_idx) ? mcor_mask : 64'h0);

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic rf_wr(input logic [4:0] a, input logic [63:0] d);
        rf_we = 1'b1; rf_a = a; rf_d = d;
    endtask

    task automatic mem_wr(input logic [11:0] a, input logic [63:0] d, input logic [7:0] be);
        mem_we = 1'b1; mem_a = a; mem_wd = d; mem_be = be;
    endtask

    task automatic idle();
        rf_we = 1'b0; mem_we = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; tick(2); rst_n = 1'b1;
    endtask

    task automatic start();
        en = 1'b1; tick(1); en = 1'b0;
    endtask

    initial begin
        n_pass = 0; n_fail = 0; n_total = 0;
        rst_n = 1'b0; en = 1'b0; rf_corrupt = '0; mcor_idx = 9'h1FF; mcor_mask = '0;
        rf_we = 1'b0; rf_a = '0; rf_d = '0; mem_we = 1'b0; mem_a = '0; mem_wd = '0; mem_be = '0;
        tick(2);
        chk("rst_done", 64'(done1), 64'd0);
        chk("rst_pass", 64'(pass1), 64'd0);
        chk("rst_err", 64'(err1), 64'd0);
        chk("rst_chk", 64'(chk1), 64'd0);
        chk("rst_cyc", 64'(cyc1), 64'd0);
        chk("rst_tohost", toh1, 64'd0);
        chk("rst_rf_rb_a", 64'(rf_rb_a1), 64'd0);
        chk("rst_mem_rb_a", 64'(mem_rb_a1), 64'd0);
        rst_n = 1'b1;
        start();

        // Clean register write
        rf_wr(5'd5, 64'hDEAD_BEEF_0000_0001); tick(1);
        chk("rf_rb_a_x5", 64'(rf_rb_a1), 64'd5);
        idle(); tick(1);
        chk("x5_chk", 64'(chk1), 64'd1);
        chk("x5_rerr", 64'(rerr1), 64'd0);
        chk("x5_err", 64'(err1), 64'd0);
        tick(3);

        // Corrupted read-back of x7
        rf_corrupt[7] = 1'b1;
        rf_wr(5'd7, 64'h12); tick(1); idle(); tick(1);
        chk("x7_err_pulse", 64'(err1), 64'd1);
        chk("x7_rerr", 64'(rerr1), 64'd1);
        chk("x7_chk", 64'(chk1), 64'd2);
        tick(1);
        chk("x7_err_low", 64'(err1), 64'd0);
        tick(2);

        // x0 write is not checked
        rf_wr(5'd0, 64'h5); tick(1); idle(); tick(1);
        chk("x0_chk", 64'(chk1), 64'd2);
        chk("x0_err", 64'(err1), 64'd0);
        tick(3);

        // Full-word store, then partial store with differing upper bytes
        mem_wr(12'h100, 64'hAAAA_BBBB_CCCC_DDDD, 8'hFF); tick(1);
        chk("mem_rb_a", 64'(mem_rb_a1), (MEMC != 0) ? 64'h100 : 64'h0);
        idle(); tick(1);
        chk("st_full_chk", 64'(chk1), 64'(2 + MEMC));
        tick(3);
        mem_wr(12'h100, 64'h1122_3344_5566_7788, 8'h0F); tick(1); idle(); tick(1);
        chk("st_part_merr", 64'(merr1), 64'd0);
        chk("st_part_err", 64'(err1), 64'd0);
        chk("st_part_chk", 64'(chk1), 64'(2 + 2*MEMC));
        tick(3);

        // Byte 0 flipped on read-back
        mcor_idx = 9'h20; mcor_mask = 64'hFF;
        mem_wr(12'h100, 64'h1122_3344_5566_7788, 8'h0F); tick(1); idle(); tick(1);
        chk("st_flip_err", 64'(err1), 64'(MEMC));
        chk("st_flip_merr", 64'(merr1), 64'(MEMC));
        chk("st_flip_chk", 64'(chk1), 64'(2 + 3*MEMC));
        tick(3);

        // Simultaneous reg and mem mismatch
        rf_wr(5'd7, 64'h34); mem_wr(12'h100, 64'h1122_3344_5566_7788, 8'h0F); tick(1);
        idle(); tick(1);
        chk("both_err1", 64'(err1), 64'd1);
        chk("both_rerr1", 64'(rerr1), 64'd2);
        chk("both_merr1", 64'(merr1), 64'(2*MEMC));
        chk("both_chk1", 64'(chk1), 64'(3 + 4*MEMC));
        chk("lat3_err_early", 64'(err3), 64'd0);
        tick(1);
        chk("both_err1_low", 64'(err1), 64'd0);
        tick(1);
        chk("lat3_err_pulse", 64'(err3), 64'd1);
        tick(1);
        chk("lat3_err_low", 64'(err3), 64'd0);
        chk("lat3_rerr", 64'(rerr3), 64'd2);
        chk("lat3_merr", 64'(merr3), 64'(2*MEMC));
        chk("lat3_chk", 64'(chk3), 64'(3 + 4*MEMC));
        tick(2);

        // Writes every cycle to distinct locations
        rf_wr(5'd1, 64'h111); mem_wr(12'h200, 64'h0101, 8'hFF); tick(1);
        rf_wr(5'd2, 64'h222); mem_wr(12'h208, 64'h0202, 8'hFF); tick(1);
        rf_wr(5'd3, 64'h333); mem_wr(12'h210, 64'h0303, 8'hFF); tick(1);
        idle(); tick(5);
        chk("stream_chk1", 64'(chk1), 64'(6 + 7*MEMC));
        chk("stream_chk3", 64'(chk3), 64'(6 + 7*MEMC));
        chk("stream_rerr3", 64'(rerr3), 64'd2);

        // TOHOST = 1 after a fresh start: pass
        do_reset();
        chk("rerun_chk3", 64'(chk3), 64'd0);
        chk("rerun_rerr3", 64'(rerr3), 64'd0);
        start();
        tick(3);
        mem_wr(12'h7F8, 64'h1, 8'hFF); tick(1); idle();
        tick(6);
        chk("drain_not_done", 64'(done1), 64'd0);
        tick(1);
        chk("th1_done", 64'(done1), 64'd1);
        chk("th1_pass", 64'(pass1), 64'd1);
        chk("th1_tohost", toh1, 64'd1);
        chk("th1_cyc", 64'(cyc1), 64'd11);
        tick(3);
        chk("th1_cyc_frozen", 64'(cyc1), 64'd11);
        chk("th1_done_held", 64'(done1), 64'd1);
        chk("th1_done3", 64'(done3), 64'd1);
        chk("th1_pass3", 64'(pass3), 64'd1);

        // TOHOST = 7: fail; a later hit during DRAIN is ignored
        do_reset();
        start();
        mem_wr(12'h7F8, 64'h7, 8'hFF); tick(1);
        mem_wr(12'h7F8, 64'h1, 8'hFF); tick(1); idle();
        tick(8);
        chk("th7_done", 64'(done1), 64'd1);
        chk("th7_pass", 64'(pass1), 64'd0);
        chk("th7_tohost", toh1, 64'd7);

        // Reset during DRAIN with two checks in flight on the LAT=3 instance
        do_reset();
        start();
        rf_corrupt[8] = 1'b1;
        rf_wr(5'd7, 64'h77); mem_wr(12'h7F8, 64'h1, 8'hFF); tick(1);
        mem_we = 1'b0; rf_wr(5'd8, 64'h88); tick(1);
        idle(); rst_n = 1'b0; tick(1);
        chk("mid_rst_err3", 64'(err3), 64'd0);
        chk("mid_rst_rerr3", 64'(rerr3), 64'd0);
        chk("mid_rst_chk3", 64'(chk3), 64'd0);
        chk("mid_rst_done3", 64'(done3), 64'd0);
        chk("mid_rst_tohost3", toh3, 64'd0);
        chk("mid_rst_rb_a3", 64'(rf_rb_a3), 64'd0);
        rst_n = 1'b1;
        tick(5);
        chk("post_rst_rerr3", 64'(rerr3), 64'd0);
        chk("post_rst_err3", 64'(err3), 64'd0);
        chk("post_rst_chk3", 64'(chk3), 64'd0);
        chk("post_rst_cyc3", 64'(cyc3), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
